// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants.
package cpu_pkg;
    localparam int WORD_W = 8;
    localparam logic [WORD_W-1:0] PC_RESET = '0;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ISSUE, S_PCW1, S_PCW2} fetch_state_t;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches from instruction memory, hands words to decode,
// and drives the two-cycle write sequence of program_counter.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = WORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_value,
    output logic               pc_we,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt,
    output logic               busy
);
    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] instr_data_q, instr_data_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0]  pc_next_q, pc_next_d;
    logic               redirect_pend_q, redirect_pend_d;
    logic [ADDR_W-1:0]  pend_target_q, pend_target_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            instr_data_q    <= '0;
            instr_pc_q      <= '0;
            pc_next_q       <= ADDR_W'(PC_RESET);
            redirect_pend_q <= 1'b0;
            pend_target_q   <= '0;
        end else begin
            state_q         <= state_d;
            instr_data_q    <= instr_data_d;
            instr_pc_q      <= instr_pc_d;
            pc_next_q       <= pc_next_d;
            redirect_pend_q <= redirect_pend_d;
            pend_target_q   <= pend_target_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        instr_data_d    = instr_data_q;
        instr_pc_d      = instr_pc_q;
        pc_next_d       = pc_next_q;
        redirect_pend_d = redirect_pend_q;
        pend_target_d   = pend_target_q;
        case (state_q)
            S_IDLE: if (!halt) state_d = S_REQ;
            S_REQ: begin
                if (redirect_valid) begin
                    redirect_pend_d = 1'b1;
                    pend_target_d   = redirect_target;
                end
                // A redirect seen during the read still waits for the ack; the data is dropped.
                if (mem_ack) begin
                    if (redirect_pend_d) begin
                        pc_next_d       = pend_target_d;
                        redirect_pend_d = 1'b0;
                        state_d         = S_PCW1;
                    end else begin
                        instr_data_d = mem_rdata;
                        instr_pc_d   = pc_value;
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (redirect_valid) begin
                    pc_next_d = redirect_target;
                    state_d   = S_PCW1;
                end else if (instr_ready) begin
                    pc_next_d = instr_pc_q + ADDR_W'(1);
                    state_d   = S_PCW1;
                end
            end
            S_PCW1: begin
                if (redirect_valid) pc_next_d = redirect_target;
                state_d = S_PCW2;
            end
            S_PCW2: begin
                // Staying here keeps write-enable high so the counter writes the target too.
                if (redirect_valid) pc_next_d = redirect_target;
                else state_d = halt ? S_IDLE : S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req     = state_q == S_REQ;
    assign mem_addr    = mem_req ? pc_value : '0;
    assign pc_we       = (state_q == S_PCW1) || (state_q == S_PCW2);
    assign pc_next     = pc_next_q;
    assign instr_valid = state_q == S_ISSUE;
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;
    assign busy        = state_q != S_IDLE;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios against a program_counter model
// (first write-enable cycle ignored) and a variable-latency memory.
module tb_instruction_fetch;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] pc_value, pc_next, mem_addr, mem_rdata, instr_data, instr_pc, redirect_target;
    logic       pc_we, mem_req, mem_ack, instr_valid, instr_ready, redirect_valid, halt, busy;
    logic [7:0] mem [256];
    logic [7:0] pc_q;
    logic       we_d;
    int         wcnt, ack_delay;
    int         checks = 0, errors = 0;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .pc_value(pc_value), .pc_we(pc_we), .pc_next(pc_next),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .instr_pc(instr_pc), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt(halt), .busy(busy)
    );

    always #5 clk = ~clk;

    // program_counter: a write lands only when enable was also high the cycle before
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= 8'h00;
            we_d <= 1'b0;
        end else begin
            we_d <= pc_we;
            if (pc_we && we_d) pc_q <= pc_next;
        end
    end
    assign pc_value = pc_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
    end
    assign mem_ack   = mem_req && (wcnt == ack_delay);
    assign mem_rdata = mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if ({pc_we, mem_req, instr_valid, busy} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {pc_we, mem_req, instr_valid, busy}); end
        checks++; if ({pc_next, mem_addr, instr_data, instr_pc} !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", {pc_next, mem_addr, instr_data, instr_pc}); end
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL halted_idle busy got %b exp 0", busy); end
        halt = 1'b0;
    endtask

    task automatic test_sequential();
        tick();
        checks++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin errors++; $display("FAIL seq_req got %b/%h exp 1/00", mem_req, mem_addr); end
        tick();
        checks++; if ({instr_valid, instr_data, instr_pc} !== {1'b1, 8'hA1, 8'h00}) begin errors++; $display("FAIL seq_issue got %b/%h/%h exp 1/a1/00", instr_valid, instr_data, instr_pc); end
        tick();
        checks++; if ({pc_we, pc_next, instr_valid} !== {1'b1, 8'h01, 1'b0}) begin errors++; $display("FAIL seq_pcw1 got %b/%h/%b exp 1/01/0", pc_we, pc_next, instr_valid); end
        tick();
        checks++; if ({pc_we, pc_value} !== {1'b1, 8'h00}) begin errors++; $display("FAIL seq_pcw2 got %b/%h exp 1/00", pc_we, pc_value); end
        tick();
        checks++; if ({pc_we, pc_value, mem_req, mem_addr} !== {1'b0, 8'h01, 1'b1, 8'h01}) begin errors++; $display("FAIL seq_next got %b/%h/%b/%h exp 0/01/1/01", pc_we, pc_value, mem_req, mem_addr); end
    endtask

    task automatic test_wrap();
        tick();
        tick();
        redirect_valid = 1'b1; redirect_target = 8'hFF;
        tick();
        redirect_valid = 1'b0;
        checks++; if ({pc_we, pc_next} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL pcw1_redirect got %b/%h exp 1/ff", pc_we, pc_next); end
        tick();
        checks++; if ({pc_value, mem_addr} !== 16'hFFFF) begin errors++; $display("FAIL wrap_req got %h/%h exp ff/ff", pc_value, mem_addr); end
        tick();
        checks++; if ({instr_data, instr_pc} !== 16'hC3FF) begin errors++; $display("FAIL wrap_issue got %h/%h exp c3/ff", instr_data, instr_pc); end
        tick();
        checks++; if (pc_next !== 8'h00) begin errors++; $display("FAIL wrap_next got %h exp 00", pc_next); end
        tick();
        tick();
        checks++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin errors++; $display("FAIL wrap_addr got %b/%h exp 1/00", mem_req, mem_addr); end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if ({instr_valid, instr_data, instr_pc, pc_we} !== {1'b1, 8'hA1, 8'h00, 1'b0}) begin errors++; $display("FAIL hold_%0d got %b/%h/%h/%b exp 1/a1/00/0", i, instr_valid, instr_data, instr_pc, pc_we); end
            if (i < 4) tick();
        end
        instr_ready = 1'b1;
        tick();
        checks++; if ({pc_we, pc_next} !== {1'b1, 8'h01}) begin errors++; $display("FAIL bp_release got %b/%h exp 1/01", pc_we, pc_next); end
        tick();
        tick();
    endtask

    task automatic test_redirect_req();
        ack_delay = 3;
        redirect_valid = 1'b1; redirect_target = 8'h40;
        tick();
        redirect_valid = 1'b0;
        checks++; if ({mem_req, instr_valid, pc_we} !== 3'b100) begin errors++; $display("FAIL req_wait got %b exp 100", {mem_req, instr_valid, pc_we}); end
        tick();
        tick();
        tick();
        checks++; if ({pc_we, pc_next, instr_valid} !== {1'b1, 8'h40, 1'b0}) begin errors++; $display("FAIL req_redirect got %b/%h/%b exp 1/40/0", pc_we, pc_next, instr_valid); end
        ack_delay = 0;
        tick();
        tick();
        checks++; if ({pc_value, mem_addr, instr_data} !== 24'h4040A1) begin errors++; $display("FAIL req_discard got %h/%h/%h exp 40/40/a1", pc_value, mem_addr, instr_data); end
    endtask

    task automatic test_redirect_issue();
        tick();
        checks++; if ({instr_valid, instr_data} !== {1'b1, 8'hD4}) begin errors++; $display("FAIL iss_valid got %b/%h exp 1/d4", instr_valid, instr_data); end
        redirect_valid = 1'b1; redirect_target = 8'h10;
        tick();
        redirect_valid = 1'b0;
        checks++; if ({instr_valid, pc_next} !== {1'b0, 8'h10}) begin errors++; $display("FAIL iss_redirect got %b/%h exp 0/10", instr_valid, pc_next); end
        tick();
        tick();
        checks++; if (mem_addr !== 8'h10) begin errors++; $display("FAIL iss_addr got %h exp 10", mem_addr); end
    endtask

    task automatic test_redirect_pcw2();
        tick();
        tick();
        checks++; if ({pc_we, pc_next} !== {1'b1, 8'h11}) begin errors++; $display("FAIL p2_pcw1 got %b/%h exp 1/11", pc_we, pc_next); end
        tick();
        checks++; if ({pc_we, pc_value} !== {1'b1, 8'h10}) begin errors++; $display("FAIL p2_pcw2 got %b/%h exp 1/10", pc_we, pc_value); end
        redirect_valid = 1'b1; redirect_target = 8'h80;
        tick();
        redirect_valid = 1'b0;
        checks++; if ({pc_we, pc_value, pc_next} !== {1'b1, 8'h11, 8'h80}) begin errors++; $display("FAIL p2_extra got %b/%h/%h exp 1/11/80", pc_we, pc_value, pc_next); end
        tick();
        checks++; if ({pc_we, pc_value, mem_addr} !== {1'b0, 8'h80, 8'h80}) begin errors++; $display("FAIL p2_done got %b/%h/%h exp 0/80/80", pc_we, pc_value, mem_addr); end
    endtask

    task automatic test_halt_reset();
        instr_ready = 1'b0;
        tick();
        halt = 1'b1;
        checks++; if ({instr_valid, instr_data} !== {1'b1, 8'hF6}) begin errors++; $display("FAIL halt_issue got %b/%h exp 1/f6", instr_valid, instr_data); end
        instr_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++; if ({busy, pc_we, mem_req, pc_value} !== {3'b000, 8'h81}) begin errors++; $display("FAIL halt_idle got %b%b%b/%h exp 000/81", busy, pc_we, mem_req, pc_value); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL halt_stay busy got %b exp 0", busy); end
        halt = 1'b0; ack_delay = 5;
        tick();
        checks++; if ({mem_req, mem_addr} !== {1'b1, 8'h81}) begin errors++; $display("FAIL resume got %b/%h exp 1/81", mem_req, mem_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({pc_we, mem_req, instr_valid, busy, pc_next, mem_addr, instr_data, instr_pc} !== 36'h0) begin errors++; $display("FAIL async_reset got %h exp 0", {pc_we, mem_req, instr_valid, busy, pc_next, mem_addr, instr_data, instr_pc}); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'hA1; mem[8'h01] = 8'hB2; mem[8'hFF] = 8'hC3;
        mem[8'h40] = 8'hD4; mem[8'h10] = 8'hE5; mem[8'h80] = 8'hF6;
        halt = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 8'h00; ack_delay = 0;
        test_reset();
        test_sequential();
        test_wrap();
        test_backpressure();
        test_redirect_req();
        test_redirect_issue();
        test_redirect_pcw2();
        test_halt_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
